// File: rtl/block_write_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | block_write_pkg : lane constants and lane-enable mask expansion  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package block_write_pkg;

  localparam int unsigned LANES          = 4;
  localparam int unsigned MAX_DATA_WIDTH = 256;

  // Expands one enable per lane into a per-bit mask; bits past LANES*lane_w stay zero.
  function automatic logic [MAX_DATA_WIDTH-1:0] lane_mask(
    input logic [LANES-1:0] lane_en,
    input int unsigned      lane_w
  );
    logic [MAX_DATA_WIDTH-1:0] mask;
    logic [1:0]                lane;
    mask = '0;
    for (int unsigned b = 0; b < MAX_DATA_WIDTH; b++) begin
      lane = 2'(b / lane_w);
      if (b < LANES * lane_w) mask[b] = lane_en[lane];
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/block_write_word_merge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | word_merge : bitwise merge of a new word into an old word        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module word_merge #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] old_i,
  input  logic [WIDTH-1:0] new_i,
  input  logic [WIDTH-1:0] mask_i,
  output logic [WIDTH-1:0] merged_o
);

  assign merged_o = (old_i & ~mask_i) | (new_i & mask_i);

endmodule
`default_nettype wire

// File: rtl/block_write.sv
`default_nettype none
// +------------------------------------------------------------------+
// | block_write : lane-masked word merge into a cache block, plus a  |
// |               registered copy of the last committed merge        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module block_write
  import block_write_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int BLOCK_SIZE = 3,
  localparam int S          = 2 ** BLOCK_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   d_in,
  input  logic [S*DATA_WIDTH-1:0] block,
  input  logic [BLOCK_SIZE-1:0]   way,
  input  logic [3:0]              lane_en,
  input  logic                    we,
  output logic [S*DATA_WIDTH-1:0] block_out,
  output logic [S*DATA_WIDTH-1:0] block_out_q,
  output logic [BLOCK_SIZE-1:0]   way_q,
  output logic                    valid_q
);

  localparam int unsigned LANE_W = DATA_WIDTH / 4;

  logic [MAX_DATA_WIDTH-1:0] full_mask;
  logic [DATA_WIDTH-1:0]     lane_bits;

  assign full_mask = lane_mask(lane_en, LANE_W);
  assign lane_bits = full_mask[DATA_WIDTH-1:0];

  if (DATA_WIDTH < MAX_DATA_WIDTH) begin : g_mask_pad
    logic unused_mask_hi;
    assign unused_mask_hi = ^full_mask[MAX_DATA_WIDTH-1:DATA_WIDTH];
  end

  // Only the addressed word sees a non-zero mask; all others pass through untouched.
  for (genvar i = 0; i < S; i++) begin : g_word
    logic [DATA_WIDTH-1:0] word_mask;
    assign word_mask = (way == BLOCK_SIZE'(i)) ? lane_bits : '0;
    word_merge #(.WIDTH(DATA_WIDTH)) u_merge (
      .old_i    (block[i*DATA_WIDTH +: DATA_WIDTH]),
      .new_i    (d_in),
      .mask_i   (word_mask),
      .merged_o (block_out[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  logic [S*DATA_WIDTH-1:0] block_out_d;
  logic [BLOCK_SIZE-1:0]   way_d;
  logic                    valid_d;

  always_comb begin
    block_out_d = block_out_q;
    way_d       = way_q;
    valid_d     = valid_q;
    if (we) begin
      block_out_d = block_out;
      way_d       = way;
      valid_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block_out_q <= '0;
      way_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      block_out_q <= block_out_d;
      way_q       <= way_d;
      valid_q     <= valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_block_write.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_block_write : scoreboard bench for block_write                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_block_write;

  localparam int DW = 32;
  localparam int BS = 3;
  localparam int S  = 8;
  localparam int BW = S * DW;

  localparam int SEL_OUT   = 0;
  localparam int SEL_OUTQ  = 1;
  localparam int SEL_WAYQ  = 2;
  localparam int SEL_VALID = 3;

  logic          clk;
  logic          rst;
  logic [DW-1:0] d_in;
  logic [BW-1:0] block;
  logic [BS-1:0] way;
  logic [3:0]    lane_en;
  logic          we;
  logic [BW-1:0] block_out;
  logic [BW-1:0] block_out_q;
  logic [BS-1:0] way_q;
  logic          valid_q;

  block_write #(.DATA_WIDTH(DW), .BLOCK_SIZE(BS)) dut (
    .clk         (clk),
    .rst         (rst),
    .d_in        (d_in),
    .block       (block),
    .way         (way),
    .lane_en     (lane_en),
    .we          (we),
    .block_out   (block_out),
    .block_out_q (block_out_q),
    .way_q       (way_q),
    .valid_q     (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    int            sel;
    logic [BW-1:0] exp;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [BW-1:0] m_block_q;
  logic [BS-1:0] m_way_q;
  logic          m_valid_q;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference merge, written lane by lane.
  function automatic logic [BW-1:0] model(input logic [BW-1:0] blk, input logic [DW-1:0] d,
                                          input int w, input logic [3:0] le);
    logic [BW-1:0] r;
    r = blk;
    for (int k = 0; k < 4; k++)
      if (le[k]) r[w*DW + k*(DW/4) +: DW/4] = d[k*(DW/4) +: DW/4];
    return r;
  endfunction

  task automatic push(input string tag, input int sel, input logic [BW-1:0] e);
    exp_t x;
    x.tag = tag; x.sel = sel; x.exp = e;
    q_exp.push_back(x);
  endtask

  task automatic push_regs(input string tag);
    logic [BW-1:0] w;
    w = '0; w[BS-1:0] = m_way_q;
    push({tag, "_blkq"}, SEL_OUTQ, m_block_q);
    push({tag, "_wayq"}, SEL_WAYQ, w);
    push({tag, "_valid"}, SEL_VALID, {{(BW-1){1'b0}}, m_valid_q});
  endtask

  task automatic drain();
    exp_t          x;
    logic [BW-1:0] obs;
    while (q_exp.size() > 0) begin
      x   = q_exp.pop_front();
      obs = '0;
      case (x.sel)
        SEL_OUT:   obs = block_out;
        SEL_OUTQ:  obs = block_out_q;
        SEL_WAYQ:  obs[BS-1:0] = way_q;
        default:   obs[0] = valid_q;
      endcase
      check(x.tag, obs, x.exp);
    end
  endtask

  task automatic drive(input logic [BW-1:0] blk, input logic [DW-1:0] d, input int w,
                       input logic [3:0] le, input logic we_v);
    block = blk; d_in = d; way = BS'(w); lane_en = le; we = we_v;
  endtask

  task automatic comb_check(input string tag);
    #1;
    push(tag, SEL_OUT, model(block, d_in, int'(way), lane_en));
    drain();
  endtask

  task automatic commit_model();
    if (!rst && we) begin
      m_block_q = model(block, d_in, int'(way), lane_en);
      m_way_q   = way;
      m_valid_q = 1'b1;
    end
  endtask

  task automatic clock_and_check(input string tag);
    commit_model();
    @(posedge clk);
    #1;
    push_regs(tag);
    drain();
  endtask

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] r;
    for (int i = 0; i < S; i++) r[i*DW +: DW] = $urandom();
    return r;
  endfunction

  logic [BW-1:0] base_blk;
  logic [BW-1:0] e;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < S; i++) base_blk[i*DW +: DW] = 32'h1111_1111 * i;
    m_block_q = '0; m_way_q = '0; m_valid_q = 1'b0;
    rst = 1'b1;
    drive(base_blk, '0, 0, 4'h0, 1'b0);
    @(negedge clk);
    #1;
    push_regs("reset");
    drain();

    @(negedge clk);
    rst = 1'b0;

    // Full-word write to word 3, with an explicit constant expectation.
    drive(base_blk, 32'hDEAD_BEEF, 3, 4'hF, 1'b0);
    e = base_blk; e[3*DW +: DW] = 32'hDEAD_BEEF;
    #1;
    push("full_w3", SEL_OUT, e);
    drain();

    drive(base_blk, 32'hAABB_CCDD, 5, 4'b0101, 1'b0);
    e = base_blk; e[5*DW +: DW] = 32'h55BB_55DD;
    #1;
    push("lane_w5", SEL_OUT, e);
    drain();

    drive(base_blk, 32'hCAFE_F00D, 0, 4'hF, 1'b0);
    e = base_blk; e[0 +: DW] = 32'hCAFE_F00D;
    #1;
    push("full_w0", SEL_OUT, e);
    drain();

    drive(base_blk, 32'h0BAD_C0DE, 7, 4'hF, 1'b0);
    e = base_blk; e[7*DW +: DW] = 32'h0BAD_C0DE;
    #1;
    push("full_w7", SEL_OUT, e);
    drain();

    drive(base_blk, 32'hFFFF_FFFF, 4, 4'h0, 1'b0);
    #1;
    push("lane_none", SEL_OUT, base_blk);
    drain();

    for (int w = 0; w < S; w++)
      for (int l = 0; l < 16; l++) begin
        drive(rand_block(), $urandom(), w, 4'(l), 1'b0);
        comb_check($sformatf("sweep_w%0d_l%0h", w, l));
      end

    // Commit of word 2, then three idle cycles with changing inputs.
    @(negedge clk);
    drive(base_blk, 32'h1234_5678, 2, 4'hF, 1'b1);
    clock_and_check("commit_w2");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(rand_block(), $urandom(), c + 4, 4'hF, 1'b0);
      clock_and_check($sformatf("hold%0d", c));
    end

    // Asynchronous reset between edges, then a commit attempt while held.
    @(negedge clk);
    rst = 1'b1;
    m_block_q = '0; m_way_q = '0; m_valid_q = 1'b0;
    #1;
    push_regs("async_rst");
    drain();
    drive(rand_block(), $urandom(), 6, 4'hF, 1'b1);
    comb_check("comb_in_rst");
    clock_and_check("we_in_rst");

    @(negedge clk);
    rst = 1'b0;
    drive(rand_block(), 32'h5A5A_A5A5, 6, 4'b1001, 1'b1);
    clock_and_check("post_rst_commit");
    @(negedge clk);
    we = 1'b0;
    clock_and_check("post_rst_hold");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
